tx_protocol: RTL
================

Name: tx_protocol

Overview:
- Sink end of the tx_data/tx_rdy/tx_eof/tx_ack stream that each channel_block drives. Handles up to two channel streams.
- On a start pulse it drains channel 1, then channel 2 (each only if enabled). Each channel's burst is preceded by a header byte.
- Every byte is forwarded to the UART transmitter through a rdy/ack byte interface.
- Sits between the channel blocks and the UART TX; it is the only consumer of the channel tx interfaces.

Parameters:
- TX_DATA_WIDTH, 8, byte width of channel and UART data.
- HEADER_CH1, 8'hC1, header byte sent before the channel 1 burst.
- HEADER_CH2, 8'hC2, header byte sent before the channel 2 burst.
- TIMEOUT_WIDTH, 16, width of the stall counter.
- TIMEOUT_CYCLES, 50000, number of consecutive cycles with source rdy low in DATA before the burst is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a transfer
- ch_enable  in  2  bit0 = send ch1, bit1 = send ch2; sampled at start
- ch1_data  in  TX_DATA_WIDTH  channel 1 byte
- ch1_rdy  in  1  channel 1 byte valid
- ch1_eof  in  1  channel 1 byte is the last of its burst
- ch1_ack  out  1  one-cycle consume pulse to channel 1
- ch2_data  in  TX_DATA_WIDTH  channel 2 byte
- ch2_rdy  in  1  channel 2 byte valid
- ch2_eof  in  1  channel 2 byte is the last of its burst
- ch2_ack  out  1  one-cycle consume pulse to channel 2
- uart_data  out  TX_DATA_WIDTH  byte to the UART
- uart_rdy  out  1  uart_data valid (level)
- uart_ack  in  1  one-cycle pulse from the UART: byte taken
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the transfer is complete
- timeout  out  1  sticky; set on any burst abort, cleared by the next accepted start

Behaviour:
Reset:
- All outputs 0; FSM in IDLE; output register empty.
- Counters 0; latched enables 0.
- Reset mid-transfer drops uart_rdy and the acks in the next cycle. No partial state survives.

Output register (single byte):
- uart_rdy = register full.
- Cleared on uart_ack while full. uart_ack while empty is ignored.
- Loaded only when empty, so there is at least one bubble cycle between bytes.
- uart_data is stable while uart_rdy is high.

Source handshake:
- In DATA for channel X, when chX_rdy=1, the output register is empty, and chX_ack was not asserted in the previous cycle:
  - load chX_data and latch chX_eof;
  - pulse chX_ack for exactly one cycle.
- The guard cycle allows the source one cycle to drop rdy or present the next byte.
- The ack of the other channel stays 0.

FSM:
- IDLE: start=1 latches ch_enable, clears timeout, sets busy.
  - Go to HDR1 if bit0 is set, else HDR2 if bit1 is set, else DONE.
  - start while busy is ignored.
- HDR1 / HDR2: when the register is empty, load HEADER_CHx, then go to DATA with sel = x.
- DATA:
  - Transfer bytes per the source handshake.
  - After the byte carrying eof is loaded, go to NEXT.
  - Stall counter: increments each cycle chX_rdy=0 and resets on any ack.
  - When the counter reaches TIMEOUT_CYCLES: set timeout and go to NEXT without further acks.
- NEXT: if sel = 1 and latched bit1 is set, go to HDR2; else go to DONE.
- DONE:
  - Wait until the output register is empty (last byte acked by the UART).
  - Then pulse done for one cycle, clear busy, and return to IDLE.
  - With both enables at 0, done pulses 2 cycles after start.

Boundary rules:
- Simultaneous start and done cycle: start is ignored (busy is still high).
- eof presented on the very first data byte: that single byte is sent, then the FSM moves on.
- chX_rdy high while the channel is not selected: ignored, no ack.
- The stall counter saturates and never wraps.

Latency:
- start to header on uart_rdy: 2 cycles.
- Source byte on rdy to uart_rdy: 1 cycle after the ack cycle.

Test Plan:
1. ch_enable=01; ch1 supplies 3 bytes 0x10,0x11,0x12 (eof on 0x12); UART acks each byte 2 cycles after uart_rdy -> UART sees C1,10,11,12; exactly 3 ch1_ack pulses, none adjacent; done pulses once; timeout=0.
2. ch_enable=11; ch1 sends 0xAA with eof, ch2 sends 0x55,0x56 with eof on 0x56 -> UART sees C1,AA,C2,55,56; ch2_ack never asserted before the C2 header is acked.
3. ch_enable=00; start pulse -> done 2 cycles later; uart_rdy never asserted; busy high for exactly those cycles.
4. TIMEOUT_CYCLES=8; ch1 sends 1 byte without eof, then holds rdy low -> after 8 stall cycles timeout=1, the FSM moves to DONE, done pulses; the next start clears timeout.
5. UART holds uart_ack low for 20 cycles with ch1_rdy high -> uart_data stable and no extra ch1_ack during the stall; the transfer resumes correctly after the ack.
6. Assert rst during ch2 DATA with uart_rdy high -> next cycle all outputs 0 and FSM in IDLE; a new start runs a full clean transfer.

Source files
------------

// File: rtl/tx_protocol.sv
`timescale 1ns/1ps
// tx_protocol: drains up to two channel byte streams, each preceded by a header byte,
// into a single-byte output register that feeds the UART transmitter over rdy/ack.
module tx_protocol #(
    parameter int                       TX_DATA_WIDTH  = 8,
    parameter logic [TX_DATA_WIDTH-1:0] HEADER_CH1     = 8'hC1,
    parameter logic [TX_DATA_WIDTH-1:0] HEADER_CH2     = 8'hC2,
    parameter int                       TIMEOUT_WIDTH  = 16,
    parameter int                       TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               ch_enable,
    input  logic [TX_DATA_WIDTH-1:0] ch1_data,
    input  logic                     ch1_rdy,
    input  logic                     ch1_eof,
    output logic                     ch1_ack,
    input  logic [TX_DATA_WIDTH-1:0] ch2_data,
    input  logic                     ch2_rdy,
    input  logic                     ch2_eof,
    output logic                     ch2_ack,
    output logic [TX_DATA_WIDTH-1:0] uart_data,
    output logic                     uart_rdy,
    input  logic                     uart_ack,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_HDR2,
        S_DATA,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] L_TIMEOUT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    state_t                     r_state;
    logic                       r_out_full;
    logic [TX_DATA_WIDTH-1:0]   r_out_data;
    logic [1:0]                 r_en;
    logic                       r_sel;       // 0 = channel 1, 1 = channel 2
    logic                       r_ack_prev;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_timeout;
    logic [TIMEOUT_WIDTH-1:0]   r_stall_cnt;

    state_t                     w_next;
    logic                       w_load;
    logic [TX_DATA_WIDTH-1:0]   w_load_data;
    logic                       w_ch1_ack;
    logic                       w_ch2_ack;
    logic                       w_any_ack;
    logic                       w_accept;
    logic                       w_abort;
    logic                       w_finish;
    logic                       w_src_rdy;
    logic                       w_src_eof;
    logic [TX_DATA_WIDTH-1:0]   w_src_data;
    logic                       w_stall_hit;

    assign w_src_rdy   = r_sel ? ch2_rdy  : ch1_rdy;
    assign w_src_eof   = r_sel ? ch2_eof  : ch1_eof;
    assign w_src_data  = r_sel ? ch2_data : ch1_data;
    assign w_stall_hit = (r_stall_cnt >= L_TIMEOUT);
    assign w_any_ack   = w_ch1_ack | w_ch2_ack;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_next      = r_state;
        w_load      = 1'b0;
        w_load_data = '0;
        w_ch1_ack   = 1'b0;
        w_ch2_ack   = 1'b0;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !r_busy) begin
                    w_accept = 1'b1;
                    if (ch_enable[0])      w_next = S_HDR1;
                    else if (ch_enable[1]) w_next = S_HDR2;
                    else                   w_next = S_DONE;
                end
            end
            S_HDR1: begin
                if (!r_out_full) begin
                    w_load      = 1'b1;
                    w_load_data = HEADER_CH1;
                    w_next      = S_DATA;
                end
            end
            S_HDR2: begin
                if (!r_out_full) begin
                    w_load      = 1'b1;
                    w_load_data = HEADER_CH2;
                    w_next      = S_DATA;
                end
            end
            S_DATA: begin
                if (w_stall_hit) begin
                    w_abort = 1'b1;
                    w_next  = S_NEXT;
                end else if (w_src_rdy && !r_out_full && !r_ack_prev) begin
                    // The guard on r_ack_prev gives the source one cycle to update rdy/data.
                    w_load      = 1'b1;
                    w_load_data = w_src_data;
                    w_ch1_ack   = !r_sel;
                    w_ch2_ack   = r_sel;
                    if (w_src_eof) w_next = S_NEXT;
                end
            end
            S_NEXT: begin
                if (!r_sel && r_en[1]) w_next = S_HDR2;
                else                   w_next = S_DONE;
            end
            S_DONE: begin
                if (!r_out_full) begin
                    w_finish = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_full  <= 1'b0;
            r_out_data  <= '0;
            r_en        <= '0;
            r_sel       <= 1'b0;
            r_ack_prev  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_ack_prev <= w_any_ack;
            r_done     <= w_finish;

            if (w_load) begin
                r_out_full <= 1'b1;
                r_out_data <= w_load_data;
            end else if (r_out_full && uart_ack) begin
                r_out_full <= 1'b0;
            end

            if (r_state == S_HDR1) r_sel <= 1'b0;
            if (r_state == S_HDR2) r_sel <= 1'b1;

            // busy drops one cycle after done so a start coinciding with done is ignored.
            if (w_accept) begin
                r_en      <= ch_enable;
                r_timeout <= 1'b0;
                r_busy    <= 1'b1;
            end else if (r_done) begin
                r_busy    <= 1'b0;
            end
            if (w_abort) r_timeout <= 1'b1;

            if (r_state != S_DATA || w_any_ack) begin
                r_stall_cnt <= '0;
            end else if (!w_src_rdy && !w_stall_hit) begin
                r_stall_cnt <= r_stall_cnt + TIMEOUT_WIDTH'(1);
            end
        end
    end

    assign ch1_ack   = w_ch1_ack;
    assign ch2_ack   = w_ch2_ack;
    assign uart_data = r_out_data;
    assign uart_rdy  = r_out_full;
    assign busy      = r_busy;
    assign done      = r_done;
    assign timeout   = r_timeout;

endmodule
